// File: rtl/hilo_unit.sv
// HI/LO register pair with move, product write/accumulate and a W-cycle
// restoring divider (signed and unsigned) that writes quotient to LO, remainder to HI.
module hilo_unit #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid,
    input  logic [2:0]     op,
    input  logic [W-1:0]   src_a,
    input  logic [W-1:0]   src_b,
    input  logic [2*W-1:0] prod,
    input  logic           flush,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   hi_o,
    output logic [W-1:0]   lo_o
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MTHI = 3'b001;
    localparam logic [2:0] OP_MTLO = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_MADD = 3'b100;
    localparam logic [2:0] OP_MSUB = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int CW = $clog2(W) + 1;

    logic [1:0]   r_state;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic [CW-1:0] r_cnt;
    logic [W:0]   r_rem;
    logic [W-1:0] r_quo;
    logic [W-1:0] r_div;
    logic [W-1:0] r_a_raw;
    logic         r_neg_q;
    logic         r_neg_r;
    logic         r_zero;

    logic           w_accept;
    logic           w_signed;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [2*W-1:0] w_hilo;
    logic [2*W-1:0] w_sum;
    logic [2*W-1:0] w_diff;
    logic [W:0]     w_shift;
    logic [W:0]     w_sub;
    logic           w_ge;
    logic [W-1:0]   w_q_fix;
    logic [W-1:0]   w_r_fix;

    // flush drops the request in the same cycle it aborts a divide
    assign w_accept = valid & ~r_busy & ~flush;

    assign w_signed = (op == OP_DIV);
    assign w_a_neg  = w_signed & src_a[W-1];
    assign w_b_neg  = w_signed & src_b[W-1];
    assign w_a_mag  = w_a_neg ? (~src_a + 1'b1) : src_a;
    assign w_b_mag  = w_b_neg ? (~src_b + 1'b1) : src_b;

    assign w_hilo = {r_hi, r_lo};
    assign w_sum  = w_hilo + prod;
    assign w_diff = w_hilo - prod;

    // Restoring step: shift the next dividend bit into the partial remainder
    assign w_shift = {r_rem[W-1:0], r_quo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift - {1'b0, r_div};

    assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem[W-1:0] + 1'b1) : r_rem[W-1:0];

    // NOTE: all state below uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_a_raw <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MTHI: r_hi <= src_a;
                            OP_MTLO: r_lo <= src_a;
                            OP_MULT: {r_hi, r_lo} <= prod;
                            OP_MADD: {r_hi, r_lo} <= w_sum;
                            OP_MSUB: {r_hi, r_lo} <= w_diff;
                            OP_DIV, OP_DIVU: begin
                                r_state <= S_CALC;
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                                r_rem   <= '0;
                                r_quo   <= w_a_mag;
                                r_div   <= w_b_mag;
                                r_a_raw <= src_a;
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                                r_zero  <= (src_b == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_ge ? w_sub : w_shift;
                        r_quo <= {r_quo[W-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(W - 1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_zero) begin
                            r_lo <= '1;
                            r_hi <= r_a_raw;
                        end else begin
                            r_lo <= w_q_fix;
                            r_hi <= w_r_fix;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign ready = ~r_busy;
    assign done  = r_done;
    assign hi_o  = r_hi;
    assign lo_o  = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit (W=32): vector tables for single-cycle ops and
// divides, plus hand sequences for busy-ignore, flush and mid-divide reset.
module tb_hilo_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MTHI = 3'b001;
    localparam logic [2:0] OP_MTLO = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b011;
    localparam logic [2:0] OP_MADD = 3'b100;
    localparam logic [2:0] OP_MSUB = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    logic           clk;
    logic           rst;
    logic           valid;
    logic [2:0]     op;
    logic [W-1:0]   src_a;
    logic [W-1:0]   src_b;
    logic [2*W-1:0] prod;
    logic           flush;
    logic           ready;
    logic           busy;
    logic           done;
    logic [W-1:0]   hi_o;
    logic [W-1:0]   lo_o;

    int checks   = 0;
    int failures = 0;

    hilo_unit #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .prod  (prod),
        .flush (flush),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     op;
        logic [W-1:0]   a;
        logic [2*W-1:0] prod;
        logic [W-1:0]   exp_hi;
        logic [W-1:0]   exp_lo;
    } sc_vec_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } div_vec_t;

    sc_vec_t  sc_tab[7];
    div_vec_t div_tab[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] p);
        valid = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        prod  = p;
        tick();
        valid = 1'b0;
        op    = OP_NOP;
    endtask

    // Issues a divide and returns in the done cycle N+W+2 after checking the busy window.
    task automatic run_div(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el, input int idx);
        int bad;
        bad = 0;
        issue(o, a, b, '0);
        for (int k = 1; k <= W + 1; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) bad++;
            tick();
        end
        check($sformatf("div[%0d] busy window errors", idx), 64'(bad), 64'd0);
        check($sformatf("div[%0d] done", idx), {63'd0, done}, 64'd1);
        check($sformatf("div[%0d] busy after", idx), {63'd0, busy}, 64'd0);
        check($sformatf("div[%0d] hi", idx), {32'd0, hi_o}, {32'd0, eh});
        check($sformatf("div[%0d] lo", idx), {32'd0, lo_o}, {32'd0, el});
    endtask

    initial begin
        int seen_done;
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;

        sc_tab[0] = '{OP_MTHI, 32'h12345678, 64'd0, 32'h12345678, 32'h00000000};
        sc_tab[1] = '{OP_MTLO, 32'h9ABCDEF0, 64'd0, 32'h12345678, 32'h9ABCDEF0};
        sc_tab[2] = '{OP_NOP,  32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'h12345678, 32'h9ABCDEF0};
        sc_tab[3] = '{OP_MULT, 32'h0, 64'h00000001_FFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
        sc_tab[4] = '{OP_MADD, 32'h0, 64'h1, 32'h00000002, 32'h00000000};
        sc_tab[5] = '{OP_MSUB, 32'h0, 64'h00000002_00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        sc_tab[6] = '{OP_MADD, 32'h0, 64'h1, 32'h00000000, 32'h00000000};

        div_tab[0] = '{OP_DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        div_tab[1] = '{OP_DIVU, 32'd100,      32'h0,        32'd100,      32'hFFFFFFFF};
        div_tab[2] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
        div_tab[3] = '{OP_DIVU, 32'hFFFFFFFF, 32'h3,        32'h0,        32'h55555555};
        div_tab[4] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD};
        div_tab[5] = '{OP_DIV,  32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        div_tab[6] = '{OP_DIV,  32'd100,      32'd7,        32'd2,        32'd14};

        rst = 1'b0; valid = 1'b0; op = OP_NOP; flush = 1'b0;
        src_a = '0; src_b = '0; prod = '0;
        tick();
        tick();
        check("reset hi", {32'd0, hi_o}, 64'd0);
        check("reset lo", {32'd0, lo_o}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        rst = 1'b1;
        tick();
        check("ready after release", {63'd0, ready}, 64'd1);

        for (int i = 0; i < 7; i++) begin
            issue(sc_tab[i].op, sc_tab[i].a, '0, sc_tab[i].prod);
            check($sformatf("sc[%0d] hi", i), {32'd0, hi_o}, {32'd0, sc_tab[i].exp_hi});
            check($sformatf("sc[%0d] lo", i), {32'd0, lo_o}, {32'd0, sc_tab[i].exp_lo});
            check($sformatf("sc[%0d] busy/done", i), {62'd0, busy, done}, 64'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_div(div_tab[i].op, div_tab[i].a, div_tab[i].b,
                    div_tab[i].exp_hi, div_tab[i].exp_lo, i);
            tick();
            check($sformatf("div[%0d] done drops", i), {63'd0, done}, 64'd0);
        end

        // MTHI during busy is ignored; MTLO in the done cycle is accepted.
        issue(OP_MTHI, 32'h5A5A5A5A, '0, '0);
        issue(OP_DIV, 32'hFFFFFFF9, 32'h2, '0);
        repeat (4) tick();
        check("ready low while busy", {63'd0, ready}, 64'd0);
        issue(OP_MTHI, 32'hDEADBEEF, '0, '0);
        check("mthi ignored while busy", {32'd0, hi_o}, 64'h5A5A5A5A);
        repeat (27) tick();
        check("busy at N+33", {62'd0, busy, done}, 64'd2);
        tick();
        check("done at N+34", {63'd0, done}, 64'd1);
        check("div -7/2 hi", {32'd0, hi_o}, 64'hFFFFFFFF);
        check("div -7/2 lo", {32'd0, lo_o}, 64'hFFFFFFFD);
        issue(OP_MTLO, 32'h0BADF00D, '0, '0);
        check("mtlo in done cycle", {32'd0, lo_o}, 64'h0BADF00D);
        check("hi after done-cycle mtlo", {32'd0, hi_o}, 64'hFFFFFFFF);

        // Flush mid-divide together with a valid MTLO.
        issue(OP_MTHI, 32'h11111111, '0, '0);
        issue(OP_MTLO, 32'h22222222, '0, '0);
        issue(OP_DIV, 32'd100, 32'd7, '0);
        repeat (9) tick();
        valid = 1'b1; op = OP_MTLO; src_a = 32'h33333333; flush = 1'b1;
        tick();
        valid = 1'b0; op = OP_NOP; flush = 1'b0;
        check("flush busy N+11", {63'd0, busy}, 64'd0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        check("flush no done", 64'(seen_done), 64'd0);
        check("flush hi kept", {32'd0, hi_o}, 64'h11111111);
        check("flush lo kept", {32'd0, lo_o}, 64'h22222222);

        // Flush in IDLE only drops the request.
        valid = 1'b1; op = OP_MTHI; src_a = 32'h44444444; flush = 1'b1;
        tick();
        valid = 1'b0; op = OP_NOP; flush = 1'b0;
        check("idle flush drops mthi", {32'd0, hi_o}, 64'h11111111);

        // Flush in the FIX cycle suppresses write and done.
        issue(OP_DIVU, 32'd50, 32'd3, '0);
        repeat (32) tick();
        check("fix cycle busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fix flush done", {62'd0, busy, done}, 64'd0);
        check("fix flush hi", {32'd0, hi_o}, 64'h11111111);
        check("fix flush lo", {32'd0, lo_o}, 64'h22222222);
        tick();
        check("fix flush done later", {63'd0, done}, 64'd0);

        // Reset in the middle of a divide.
        issue(OP_DIV, 32'd100, 32'd7, '0);
        repeat (19) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midreset hi", {32'd0, hi_o}, 64'd0);
        check("midreset lo", {32'd0, lo_o}, 64'd0);
        check("midreset busy/done", {62'd0, busy, done}, 64'd0);
        tick();
        check("midreset ready", {63'd0, ready}, 64'd1);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        check("midreset no done", 64'(seen_done), 64'd0);
        run_div(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
